// File: rtl/cache_arbiter_if.sv
// Bundle between the two processors, the arbiter and the cache.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface cache_arbiter_if #(
  parameter int REQ_W = 22
);
  logic             p0_req_valid;
  logic [REQ_W-1:0] p0_request;
  logic             p0_req_ready;
  logic             p1_req_valid;
  logic [REQ_W-1:0] p1_request;
  logic             p1_req_ready;
  logic             cache_req_valid;
  logic             cache_busy;
  logic [REQ_W-1:0] cache_resp;
  logic             cache_resp_valid;
  logic [REQ_W-1:0] resp_data;
  logic             p0_resp_valid;
  logic             p1_resp_valid;
  logic             grant_id;
  logic             timeout_pulse;
  logic             id_err;

  modport slave (
    input  p0_req_valid, p0_request, p1_req_valid, p1_request,
           cache_busy, cache_resp, cache_resp_valid,
    output p0_req_ready, p1_req_ready, cache_req_valid, resp_data,
           p0_resp_valid, p1_resp_valid, grant_id, timeout_pulse, id_err
  );

  modport master (
    output p0_req_valid, p0_request, p1_req_valid, p1_request,
           cache_busy, cache_resp, cache_resp_valid,
    input  p0_req_ready, p1_req_ready, cache_req_valid, resp_data,
           p0_resp_valid, p1_resp_valid, grant_id, timeout_pulse, id_err
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-processor round-robin arbiter in front of a single-outstanding cache port.
// One-entry holding buffer per processor; timed-out requests stay buffered for retry.
module cache_arbiter #(
  parameter int REQ_W   = 22,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  cache_arbiter_if.slave   bus,
  output logic [REQ_W-1:0] cache_request
);
  localparam int NUM_LANES = 2;
  localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                              state, state_nxt;
  logic [NUM_LANES-1:0]                buf_full, rdy_q, req_valid, capture, release_buf;
  logic [NUM_LANES-1:0][REQ_W-1:0]     buf_q, req_word;
  logic [NUM_LANES-1:0]                resp_v;
  logic                                rr, grant_id, grant_nxt;
  logic [CW-1:0]                       cnt;
  logic                                match, timeout_hit, tmo_q, id_err_q;
  logic [REQ_W-1:0]                    resp_q;
  logic                                unused_id_bits;

  assign req_valid      = {bus.p1_req_valid, bus.p0_req_valid};
  assign req_word       = {bus.p1_request, bus.p0_request};
  assign unused_id_bits = ^{bus.p0_request[REQ_W-1], bus.p1_request[REQ_W-1]};

  assign match       = (state == WAIT) && bus.cache_resp_valid &&
                       (bus.cache_resp[REQ_W-1] == grant_id);
  assign timeout_hit = (state == WAIT) && !match && (cnt == CW'(TIMEOUT - 1));
  assign grant_nxt   = (&buf_full) ? rr : buf_full[1];

  // Holding buffers: the id bit is stamped with the lane index on capture.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_buf
    localparam logic [0:0] ID = 1'(i);
    assign capture[i]     = req_valid[i] && rdy_q[i];
    assign release_buf[i] = match && (grant_id == ID);

    always_ff @(posedge clk) begin
      if (!reset) begin
        buf_full[i] <= 1'b0;
        rdy_q[i]    <= 1'b0;
        buf_q[i]    <= '0;
      end else begin
        if (release_buf[i])  buf_full[i] <= 1'b0;
        else if (capture[i]) begin
          buf_full[i] <= 1'b1;
          buf_q[i]    <= {ID, req_word[i][REQ_W-2:0]};
        end
        rdy_q[i] <= release_buf[i] || (!capture[i] && !buf_full[i]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|buf_full)               state_nxt = ISSUE;
      ISSUE:   if (!bus.cache_busy)         state_nxt = WAIT;
      WAIT:    if (match || timeout_hit)    state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rr       <= 1'b0;
      grant_id <= 1'b0;
      cnt      <= '0;
      resp_q   <= '0;
      resp_v   <= '0;
      tmo_q    <= 1'b0;
      id_err_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      resp_v <= '0;
      tmo_q  <= 1'b0;
      if (state == IDLE && |buf_full) grant_id <= grant_nxt;
      if (state == ISSUE)             cnt <= '0;
      else if (state == WAIT)         cnt <= cnt + 1'b1;
      if (match) begin
        resp_q           <= bus.cache_resp;
        resp_v[grant_id] <= 1'b1;
        rr               <= ~grant_id;
      end
      // Abandoned request stays buffered; the other side gets the next turn.
      if (timeout_hit) begin
        tmo_q <= 1'b1;
        rr    <= ~grant_id;
      end
      if (state == WAIT && bus.cache_resp_valid && !match) id_err_q <= 1'b1;
    end
  end

  assign cache_request       = (state == ISSUE) ? buf_q[grant_id] : {REQ_W{1'bz}};
  assign bus.cache_req_valid = (state == ISSUE);
  assign bus.p0_req_ready    = rdy_q[0];
  assign bus.p1_req_ready    = rdy_q[1];
  assign bus.resp_data       = resp_q;
  assign bus.p0_resp_valid   = resp_v[0];
  assign bus.p1_resp_valid   = resp_v[1];
  assign bus.grant_id        = grant_id;
  assign bus.timeout_pulse   = tmo_q;
  assign bus.id_err          = id_err_q;
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter REQ_W, default 22: request/response word width. Fields from MSB down are proc id [21], load/store flag [20] (0=load, 1=store), tag [19:9], block offset [8], data [7:0].
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent in WAIT before abandoning a transaction.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 p0_req_valid  in  1  processor 0 presents a request.
REQ-006 p0_request  in  REQ_W  processor 0 request word.
REQ-007 p0_req_ready  out  1  processor 0 holding buffer is empty.
REQ-008 p1_req_valid, p1_request, p1_req_ready: same directions, widths and meanings as REQ-005..007, for processor 1.
REQ-009 cache_request  out  REQ_W  request to the cache; driven 'bz whenever cache_req_valid=0.
REQ-010 cache_req_valid  out  1  cache_request is valid.
REQ-011 cache_busy  in  1  cache cannot accept a request this cycle.
REQ-012 cache_resp  in  REQ_W  cache data_out word.
REQ-013 cache_resp_valid  in  1  cache_resp is valid.
REQ-014 resp_data  out  REQ_W  registered copy of the matched cache_resp, broadcast to both processors.
REQ-015 p0_resp_valid / p1_resp_valid  out  1 each  one-cycle pulse: resp_data belongs to that processor.
REQ-016 grant_id  out  1  processor currently or last granted.
REQ-017 timeout_pulse  out  1  one-cycle pulse when a WAIT is abandoned.
REQ-018 id_err  out  1  sticky flag: a response was received with the wrong proc id.

Function
REQ-019 Each processor SHALL have a one-entry holding buffer. A request is captured on an edge where pX_req_valid=1 and pX_req_ready=1. pX_req_ready = buffer empty, registered.
REQ-020 Bit [21] of a captured word SHALL be overwritten with the processor index, whatever the requester drove.
REQ-021 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT.
REQ-022 IDLE: if any buffer is full, grant by round-robin pointer rr. If both buffers are full, grant processor rr; if only one is full, grant that one. Latch grant_id and go to ISSUE.
REQ-023 ISSUE: cache_req_valid=1 and cache_request = granted buffer. Leave ISSUE for WAIT on the first edge with cache_busy=0; hold all outputs while cache_busy=1.
REQ-024 WAIT: an edge with cache_resp_valid=1 and cache_resp[21]=grant_id SHALL register resp_data, pulse p<grant_id>_resp_valid for one cycle, empty the granted buffer, set rr to the other processor and go to IDLE.
REQ-025 In WAIT, cache_resp_valid=1 with cache_resp[21]!=grant_id SHALL set id_err and be otherwise ignored.
REQ-026 A WAIT cycle counter SHALL be cleared on entry to WAIT. When it reaches TIMEOUT-1 without a match: pulse timeout_pulse, keep the buffer full so the request is retried, set rr to the other processor and go to IDLE.
REQ-027 Minimum latency: capture at edge k gives cache_req_valid=1 after edge k+1; with cache_busy=0 and an immediate response, the resp pulse follows edge k+3.
REQ-028 A buffer being freed SHALL NOT accept a new word on the same edge; ready rises one cycle later.
REQ-029 Only one transaction SHALL be outstanding at a time. No new grant is made outside IDLE.

Reset
REQ-030 An edge with reset=0 SHALL force: state=IDLE, both buffers empty, rr=0, counter=0, cache_req_valid=0, cache_request='bz, pX_resp_valid=0, timeout_pulse=0, id_err=0, grant_id=0, resp_data=0.
REQ-031 pX_req_ready SHALL be 0 during reset and 1 on the first cycle after reset is released.
REQ-032 Reset asserted mid-ISSUE or mid-WAIT SHALL abandon the transaction silently, with no response or timeout pulse.

Verification
REQ-033 Single load: p0 sends 22'b0_0_01011010000_0_00000000, cache_busy=0, response one cycle after issue -> cache_request matches the sent word, p0_resp_valid pulses once, p0_req_ready returns to 1.
REQ-034 Contention: both processors valid in the same cycle after reset -> p0 served first, then p1. Next simultaneous pair -> p0 served first again, because rr returns to 0 after p1 completes.
REQ-035 Busy stall: cache_busy=1 for 5 cycles during ISSUE -> cache_request held stable for all 5 cycles, WAIT entered on the 6th edge.
REQ-036 Wrong id: p1 granted, response arrives with bit21=0 -> id_err=1, no resp pulse. Correct response afterwards -> p1_resp_valid pulses.
REQ-037 Timeout: no response for 16 cycles -> timeout_pulse fires, buffer still full, request reissued after the other processor is served.
REQ-038 Reset low during WAIT -> all outputs at REQ-030 values next cycle and no response pulse ever delivered for the abandoned request.
